xnor_eq_accum: RTL and testbench
================================

Name: xnor_eq_accum

Overview:
- Word-serial equality accumulator that sits directly downstream of the 3-bit two-input XNOR bank.
- Consumes one 4-bit XNOR result word per accepted beat and ANDs the match bits across a multi-beat operand.
- Reports a registered equal/not-equal verdict at the end of each operand, plus the beat count and an overflow flag.
- Used to compare operands wider than 3 bits, 3 bits per cycle.

Parameters:
- MAX_BEATS, 8, maximum number of beats per comparison; beats beyond this set ovf.
- CW, 4, width of beat counter; must satisfy 2^CW > MAX_BEATS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new comparison (single-cycle pulse).
- in_valid  input  1  xn carries a beat.
- in_last  input  1  final beat of the operand; qualified by in_valid.
- xn  input  4  XNOR word from the upstream bank; xn[2:0] are the match bits, xn[3] is ignored (upstream ties it 0).
- in_ready  output  1  block accepts a beat this cycle.
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse; verdict valid.
- eq  output  1  1 = every bit of every beat matched; held until next start.
- beat_cnt  output  CW  beats accepted in current or last comparison (saturating).
- ovf  output  1  more than MAX_BEATS beats were offered; held until next start.

Behaviour:
- Reset (async, any state):
  - state=IDLE; acc=1.
  - in_ready, busy, done, eq, ovf = 0; beat_cnt = 0.
- Handshake: a beat is accepted only when in_valid && in_ready. in_ready is a pure function of state: 1 only in ACC.
- IDLE:
  - in_ready=0, busy=0; in_valid is ignored.
  - start -> ACC; acc<=1, beat_cnt<=0, eq<=0, ovf<=0.
- ACC:
  - in_ready=1, busy=1.
  - On an accepted beat: acc <= acc & xn[0] & xn[1] & xn[2].
  - If beat_cnt < MAX_BEATS, beat_cnt++. Otherwise beat_cnt holds, ovf<=1, acc<=0.
  - in_last on an accepted beat -> DONE.
  - start in ACC aborts and restarts: counters and acc are cleared exactly as from IDLE, and any beat presented that cycle is discarded (start wins).
- DONE (one cycle):
  - done=1, busy=0, in_ready=0; eq=acc is registered on entry, so eq is valid in this cycle.
  - start in DONE -> ACC with clear; otherwise -> IDLE.
- Latency: done and eq are asserted on the first clock edge after the in_last beat is accepted (1 cycle).
- Boundaries:
  - Single-beat operand (in_last on the first beat) is legal.
  - beat_cnt saturates at MAX_BEATS and never wraps.
  - in_last without in_valid has no effect.
  - Reset mid-comparison drops the operand; no done pulse is produced.

Optional Feature:
- Macro: XNOR_EQ_FIRST_MISS_EN.
- When defined, three extra outputs are added:
  - miss_vld (1): set on the first accepted beat whose xn[2:0] != 3'b111.
  - miss_idx (CW): beat_cnt value before increment on that beat, i.e. the zero-based index of the mismatching beat.
  - miss_bit (3): ~xn[2:0] captured on that beat.
- These outputs are captured only once per comparison, cleared by start and by rst, and held through DONE/IDLE.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 with start=1 and in_valid=1 -> every output stays 0, in_ready=0; release, 2 idle cycles -> still IDLE.
- All match: start; beats xn=4'b0111, 4'b0111, 4'b0111(last) on consecutive cycles -> next cycle done=1, eq=1, beat_cnt=3, ovf=0; done low the following cycle, eq held at 1.
- Mismatch: start; beats 4'b0111, 4'b0101, 4'b0111(last) -> done=1, eq=0, beat_cnt=3; with XNOR_EQ_FIRST_MISS_EN, miss_vld=1, miss_idx=1, miss_bit=3'b010.
- Bit3 ignored: start; beats 4'b1111, 4'b1111(last) -> eq=1, beat_cnt=2.
- Overflow (MAX_BEATS=8): start; 10 beats of 4'b0111, last on the 10th -> ovf=1, eq=0, beat_cnt=8.
- Abort and reset:
  - Start, accept 2 beats, pulse start with in_valid=1, xn=4'b0000 -> beat discarded, beat_cnt=0; then one beat 4'b0111(last) -> eq=1, beat_cnt=1.
  - Separately, assert rst mid-ACC -> outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/xnor_eq_accum_if.sv
// rtl/xnor_eq_accum_if.sv - beat/handshake/verdict bundle for xnor_eq_accum (miss outputs under XNOR_EQ_FIRST_MISS_EN)
interface xnor_eq_accum_if #(
  parameter int CW = 4
);
  // Upstream side: command pulse and XNOR beat stream
  logic          start;
  logic          in_valid;
  logic          in_last;
  logic [3:0]    xn;
  // Block side: handshake, status and verdict
  logic          in_ready;
  logic          busy;
  logic          done;
  logic          eq;
  logic [CW-1:0] beat_cnt;
  logic          ovf;
`ifdef XNOR_EQ_FIRST_MISS_EN
  logic          miss_vld;
  logic [CW-1:0] miss_idx;
  logic [2:0]    miss_bit;
`endif

  // The accumulator consumes beats and drives the verdict
  modport slave (
    input  start, in_valid, in_last, xn,
    output in_ready, busy, done, eq, beat_cnt, ovf
`ifdef XNOR_EQ_FIRST_MISS_EN
    , output miss_vld, miss_idx, miss_bit
`endif
  );

  // The producer drives beats and observes the verdict
  modport master (
    output start, in_valid, in_last, xn,
    input  in_ready, busy, done, eq, beat_cnt, ovf
`ifdef XNOR_EQ_FIRST_MISS_EN
    , input miss_vld, miss_idx, miss_bit
`endif
  );
endinterface

// File: rtl/xnor_eq_accum.sv
// rtl/xnor_eq_accum.sv - word-serial XNOR equality accumulator; optional first-miss capture via XNOR_EQ_FIRST_MISS_EN
module xnor_eq_accum #(
  parameter int MAX_BEATS = 8,
  parameter int CW        = 4
) (
  input  logic           clk,
  input  logic           rst,
  xnor_eq_accum_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  state_t        state_q, state_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          eq_q, eq_d;
  logic          ovf_q, ovf_d;
  logic          beat_acc;
  logic          beat_match;

  // xn[3] is tied low upstream and carries no match information
  logic unused_xn3;
  assign unused_xn3 = bus.xn[3];

  // A beat counts only in ACC, and a coincident start discards it
  assign beat_acc   = (state_q == S_ACC) && bus.in_valid && !bus.start;
  assign beat_match = &bus.xn[2:0];

  // Next-state, accumulator, counter and verdict logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACC;
          acc_d   = 1'b1;
          cnt_d   = '0;
          eq_d    = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_ACC: begin
        if (bus.start) begin
          acc_d = 1'b1;
          cnt_d = '0;
          eq_d  = 1'b0;
          ovf_d = 1'b0;
        end else if (beat_acc) begin
          if (cnt_q < MAX_CNT) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_q & beat_match;
          end else begin
            // Excess beats poison the verdict; the counter saturates
            ovf_d = 1'b1;
            acc_d = 1'b0;
          end
          if (bus.in_last) begin
            state_d = S_DONE;
            eq_d    = acc_d;
          end
        end
      end
      S_DONE: begin
        if (bus.start) begin
          state_d = S_ACC;
          acc_d   = 1'b1;
          cnt_d   = '0;
          eq_d    = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 1'b1;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready = (state_q == S_ACC);
  assign bus.busy     = (state_q == S_ACC);
  assign bus.done     = (state_q == S_DONE);
  assign bus.eq       = eq_q;
  assign bus.beat_cnt = cnt_q;
  assign bus.ovf      = ovf_q;

`ifdef XNOR_EQ_FIRST_MISS_EN
  logic          miss_vld_q, miss_vld_d;
  logic [CW-1:0] miss_idx_q, miss_idx_d;
  logic [2:0]    miss_bit_q, miss_bit_d;

  // Capture the first mismatching beat once per comparison; start clears
  always_comb begin
    miss_vld_d = miss_vld_q;
    miss_idx_d = miss_idx_q;
    miss_bit_d = miss_bit_q;
    if (bus.start) begin
      miss_vld_d = 1'b0;
      miss_idx_d = '0;
      miss_bit_d = '0;
    end else if (beat_acc && !beat_match && !miss_vld_q) begin
      miss_vld_d = 1'b1;
      miss_idx_d = cnt_q;
      miss_bit_d = ~bus.xn[2:0];
    end
  end

  // First-miss registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_vld_q <= 1'b0;
      miss_idx_q <= '0;
      miss_bit_q <= '0;
    end else begin
      miss_vld_q <= miss_vld_d;
      miss_idx_q <= miss_idx_d;
      miss_bit_q <= miss_bit_d;
    end
  end

  assign bus.miss_vld = miss_vld_q;
  assign bus.miss_idx = miss_idx_q;
  assign bus.miss_bit = miss_bit_q;
`endif

endmodule

// File: tb/tb_xnor_eq_accum.sv
// tb/tb_xnor_eq_accum.sv - directed self-checking bench for xnor_eq_accum
module tb_xnor_eq_accum;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  xnor_eq_accum_if #(.CW(4)) bus ();

  xnor_eq_accum #(.MAX_BEATS(8), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.xn       = 4'b0000;
  endtask

  task automatic do_start();
    idle_inputs();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic beat(input logic [3:0] x, input logic last);
    bus.in_valid = 1'b1;
    bus.xn       = x;
    bus.in_last  = last;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.xn       = 4'b0111;
    repeat (3) step();
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
    n_chk++; if (bus.eq !== 1'b0) begin n_fail++; $display("FAIL rst_eq: got %b want 0", bus.eq); end
    n_chk++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
    n_chk++; if (bus.beat_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", bus.beat_cnt); end
    idle_inputs();
    rst = 1'b0;
    repeat (2) step();
    n_chk++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: busy=%b rdy=%b want 0 0", bus.busy, bus.in_ready); end
  endtask

  task automatic test_all_match();
    do_start();
    n_chk++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL am_acc: busy=%b rdy=%b want 1 1", bus.busy, bus.in_ready); end
    n_chk++; if (bus.beat_cnt !== 4'd0) begin n_fail++; $display("FAIL am_cnt0: got %0d want 0", bus.beat_cnt); end
    beat(4'b0111, 1'b0);
    beat(4'b0111, 1'b0);
    n_chk++; if (bus.done !== 1'b0 || bus.beat_cnt !== 4'd2) begin n_fail++; $display("FAIL am_mid: done=%b cnt=%0d want 0 2", bus.done, bus.beat_cnt); end
    beat(4'b0111, 1'b1);
    n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL am_done: got %b want 1", bus.done); end
    n_chk++; if (bus.eq !== 1'b1) begin n_fail++; $display("FAIL am_eq: got %b want 1", bus.eq); end
    n_chk++; if (bus.beat_cnt !== 4'd3) begin n_fail++; $display("FAIL am_cnt: got %0d want 3", bus.beat_cnt); end
    n_chk++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL am_ovf: got %b want 0", bus.ovf); end
    n_chk++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL am_done_hs: busy=%b rdy=%b want 0 0", bus.busy, bus.in_ready); end
`ifdef XNOR_EQ_FIRST_MISS_EN
    n_chk++; if (bus.miss_vld !== 1'b0) begin n_fail++; $display("FAIL am_miss_vld: got %b want 0", bus.miss_vld); end
`endif
    step();
    n_chk++; if (bus.done !== 1'b0 || bus.eq !== 1'b1) begin n_fail++; $display("FAIL am_hold: done=%b eq=%b want 0 1", bus.done, bus.eq); end
  endtask

  task automatic test_mismatch();
    do_start();
    n_chk++; if (bus.eq !== 1'b0) begin n_fail++; $display("FAIL mm_eq_clr: got %b want 0", bus.eq); end
    beat(4'b0111, 1'b0);
    beat(4'b0101, 1'b0);
    // in_last without in_valid must not end the operand
    bus.in_last = 1'b1;
    step();
    bus.in_last = 1'b0;
    n_chk++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL mm_last_novalid: busy=%b done=%b want 1 0", bus.busy, bus.done); end
    beat(4'b0111, 1'b1);
    n_chk++; if (bus.done !== 1'b1 || bus.eq !== 1'b0) begin n_fail++; $display("FAIL mm_verdict: done=%b eq=%b want 1 0", bus.done, bus.eq); end
    n_chk++; if (bus.beat_cnt !== 4'd3) begin n_fail++; $display("FAIL mm_cnt: got %0d want 3", bus.beat_cnt); end
`ifdef XNOR_EQ_FIRST_MISS_EN
    n_chk++; if (bus.miss_vld !== 1'b1) begin n_fail++; $display("FAIL mm_miss_vld: got %b want 1", bus.miss_vld); end
    n_chk++; if (bus.miss_idx !== 4'd1) begin n_fail++; $display("FAIL mm_miss_idx: got %0d want 1", bus.miss_idx); end
    n_chk++; if (bus.miss_bit !== 3'b010) begin n_fail++; $display("FAIL mm_miss_bit: got %b want 010", bus.miss_bit); end
`endif
    step();
  endtask

  task automatic test_bit3_ignored();
    do_start();
    beat(4'b1111, 1'b0);
    beat(4'b1111, 1'b1);
    n_chk++; if (bus.done !== 1'b1 || bus.eq !== 1'b1) begin n_fail++; $display("FAIL b3_verdict: done=%b eq=%b want 1 1", bus.done, bus.eq); end
    n_chk++; if (bus.beat_cnt !== 4'd2) begin n_fail++; $display("FAIL b3_cnt: got %0d want 2", bus.beat_cnt); end
    step();
  endtask

  task automatic test_overflow();
    do_start();
    for (int i = 0; i < 8; i++) beat(4'b0111, 1'b0);
    n_chk++; if (bus.beat_cnt !== 4'd8 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ov_at_max: cnt=%0d ovf=%b want 8 0", bus.beat_cnt, bus.ovf); end
    beat(4'b0111, 1'b0);
    n_chk++; if (bus.beat_cnt !== 4'd8 || bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ov_ninth: cnt=%0d ovf=%b want 8 1", bus.beat_cnt, bus.ovf); end
    beat(4'b0111, 1'b1);
    n_chk++; if (bus.done !== 1'b1 || bus.eq !== 1'b0) begin n_fail++; $display("FAIL ov_verdict: done=%b eq=%b want 1 0", bus.done, bus.eq); end
    n_chk++; if (bus.ovf !== 1'b1 || bus.beat_cnt !== 4'd8) begin n_fail++; $display("FAIL ov_final: ovf=%b cnt=%0d want 1 8", bus.ovf, bus.beat_cnt); end
    step();
    n_chk++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ov_hold: got %b want 1", bus.ovf); end
    do_start();
    n_chk++; if (bus.ovf !== 1'b0 || bus.beat_cnt !== 4'd0) begin n_fail++; $display("FAIL ov_clear: ovf=%b cnt=%0d want 0 0", bus.ovf, bus.beat_cnt); end
    beat(4'b0111, 1'b1);
    step();
  endtask

  task automatic test_abort();
    do_start();
    beat(4'b0111, 1'b0);
    beat(4'b0111, 1'b0);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.xn       = 4'b0000;
    step();
    idle_inputs();
    n_chk++; if (bus.beat_cnt !== 4'd0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL ab_restart: cnt=%0d busy=%b want 0 1", bus.beat_cnt, bus.busy); end
    beat(4'b0111, 1'b1);
    n_chk++; if (bus.done !== 1'b1 || bus.eq !== 1'b1) begin n_fail++; $display("FAIL ab_verdict: done=%b eq=%b want 1 1", bus.done, bus.eq); end
    n_chk++; if (bus.beat_cnt !== 4'd1) begin n_fail++; $display("FAIL ab_cnt: got %0d want 1", bus.beat_cnt); end
  endtask

  task automatic test_back_to_back();
    // Still in DONE from the previous task: start goes straight to ACC
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_chk++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL bb_restart: busy=%b done=%b want 1 0", bus.busy, bus.done); end
    n_chk++; if (bus.eq !== 1'b0 || bus.beat_cnt !== 4'd0) begin n_fail++; $display("FAIL bb_clear: eq=%b cnt=%0d want 0 0", bus.eq, bus.beat_cnt); end
    beat(4'b0011, 1'b1);
    n_chk++; if (bus.done !== 1'b1 || bus.eq !== 1'b0 || bus.beat_cnt !== 4'd1) begin n_fail++; $display("FAIL bb_verdict: done=%b eq=%b cnt=%0d want 1 0 1", bus.done, bus.eq, bus.beat_cnt); end
`ifdef XNOR_EQ_FIRST_MISS_EN
    n_chk++; if (bus.miss_idx !== 4'd0 || bus.miss_bit !== 3'b100) begin n_fail++; $display("FAIL bb_miss: idx=%0d bit=%b want 0 100", bus.miss_idx, bus.miss_bit); end
`endif
    step();
  endtask

  task automatic test_reset_mid();
    do_start();
    beat(4'b0111, 1'b0);
    beat(4'b0111, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.beat_cnt !== 4'd0) begin n_fail++; $display("FAIL rm_async: busy=%b rdy=%b cnt=%0d want 0 0 0", bus.busy, bus.in_ready, bus.beat_cnt); end
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.xn       = 4'b0111;
    step();
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rm_done_in_rst: got %b want 0", bus.done); end
    idle_inputs();
    rst = 1'b0;
    repeat (2) begin
      step();
      n_chk++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_after: done=%b busy=%b want 0 0", bus.done, bus.busy); end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_all_match();
    test_mismatch();
    test_bit3_ignored();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
